// File: rtl/pipe_adder.sv
// pipe_adder: valid/ready pipelined unsigned add/sub with optional saturation.
// Arithmetic resolves before the first register; later stages only delay the beat.
module pipe_adder #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter bit SAT    = 1'b0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             ovf
);

   logic [WIDTH:0]   w_raw;
   logic [WIDTH-1:0] w_res;
   logic             w_adv;

   logic [STAGES-1:0] r_vld;
   logic [STAGES-1:0] r_cy;
   logic [WIDTH-1:0]  r_sum [STAGES];

   // Raw (WIDTH+1)-bit result; bit WIDTH is carry on add, borrow on sub.
   always_comb begin
      w_raw = '0;
      if (sub) begin
         w_raw = {1'b0, a} - {1'b0, b};
      end else begin
         w_raw = {1'b0, a} + {1'b0, b};
      end
   end

   // Clamp to all-ones on add overflow or zero on sub borrow when saturating.
   always_comb begin
      w_res = w_raw[WIDTH-1:0];
      if (SAT && w_raw[WIDTH]) begin
         w_res = sub ? '0 : {WIDTH{1'b1}};
      end
   end

   assign out_valid = r_vld[STAGES-1];
   assign in_ready  = out_ready || !out_valid;
   assign w_adv     = in_ready;

   assign sum   = r_sum[STAGES-1];
   assign carry = r_cy[STAGES-1];
   assign ovf   = r_cy[STAGES-1];

   // Shift the whole pipeline on advance; hold every stage otherwise.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_vld <= '0;
         r_cy  <= '0;
         for (int i = 0; i < STAGES; i++) begin
            r_sum[i] <= '0;
         end
      end else if (w_adv) begin
         r_vld[0] <= in_valid;
         if (in_valid) begin
            r_sum[0] <= w_res;
            r_cy[0]  <= w_raw[WIDTH];
         end
         for (int i = 1; i < STAGES; i++) begin
            r_vld[i] <= r_vld[i-1];
            if (r_vld[i-1]) begin
               r_sum[i] <= r_sum[i-1];
               r_cy[i]  <= r_cy[i-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed checks of pipe_adder, wrap and saturating builds.
// Both instances share stimulus; each scenario task checks its own results.
module tb_pipe_adder;

   logic       clk;
   logic       rstn;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic       sub;
   logic       out_ready;

   logic       rdy0, ov0, cy0, of0;
   logic [7:0] s0;
   logic       rdy1, ov1, cy1, of1;
   logic [7:0] s1;

   int n_tests = 0;
   int n_fail  = 0;

   pipe_adder #(.WIDTH(8), .STAGES(2), .SAT(1'b0)) u_wrap (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy0),
      .a(a), .b(b), .sub(sub), .out_valid(ov0), .out_ready(out_ready),
      .sum(s0), .carry(cy0), .ovf(of0)
   );

   pipe_adder #(.WIDTH(8), .STAGES(2), .SAT(1'b1)) u_sat (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy1),
      .a(a), .b(b), .sub(sub), .out_valid(ov1), .out_ready(out_ready),
      .sum(s1), .carry(cy1), .ovf(of1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] xa,
                        input logic [7:0] xb, input logic xs);
      in_valid = v;
      a = xa;
      b = xb;
      sub = xs;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 8'd0, 8'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({ov0, s0, cy0, of0, rdy0} !== 12'h001) begin
         n_fail++;
         $display("FAIL reset_wrap got %h want 001",
                  {ov0, s0, cy0, of0, rdy0});
      end
      n_tests++;
      if ({ov1, s1, cy1, of1, rdy1} !== 12'h001) begin
         n_fail++;
         $display("FAIL reset_sat got %h want 001",
                  {ov1, s1, cy1, of1, rdy1});
      end
      rstn = 1'b1;
   endtask

   task automatic test_basic_add();
      drive(1'b1, 8'd15, 8'd10, 1'b0);
      tick();
      drive(1'b0, 8'd99, 8'd99, 1'b1);
      n_tests++;
      if (ov0 !== 1'b0) begin
         n_fail++;
         $display("FAIL add_early got valid=%b want 0", ov0);
      end
      tick();
      n_tests++;
      if ({ov0, s0, cy0, of0} !== {1'b1, 8'd25, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL add_out got v=%b s=%0d c=%b o=%b want 1 25 0 0",
                  ov0, s0, cy0, of0);
      end
      tick();
      n_tests++;
      if (ov0 !== 1'b0) begin
         n_fail++;
         $display("FAIL add_once got valid=%b want 0", ov0);
      end
   endtask

   task automatic test_overflow();
      drive(1'b1, 8'd200, 8'd100, 1'b0);
      tick();
      drive(1'b0, 8'd0, 8'd0, 1'b0);
      tick();
      n_tests++;
      if ({ov0, s0, cy0, of0} !== {1'b1, 8'd44, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL ovf_wrap got v=%b s=%0d c=%b o=%b want 1 44 1 1",
                  ov0, s0, cy0, of0);
      end
      n_tests++;
      if ({ov1, s1, cy1, of1} !== {1'b1, 8'd255, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL ovf_sat got v=%b s=%0d c=%b o=%b want 1 255 1 1",
                  ov1, s1, cy1, of1);
      end
   endtask

   task automatic test_borrow();
      drive(1'b1, 8'd10, 8'd25, 1'b1);
      tick();
      drive(1'b1, 8'd25, 8'd10, 1'b1);
      tick();
      drive(1'b0, 8'd0, 8'd0, 1'b0);
      n_tests++;
      if ({ov0, s0, cy0, of0} !== {1'b1, 8'd241, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL brw_wrap got v=%b s=%0d c=%b o=%b want 1 241 1 1",
                  ov0, s0, cy0, of0);
      end
      n_tests++;
      if ({ov1, s1, cy1, of1} !== {1'b1, 8'd0, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL brw_sat got v=%b s=%0d c=%b o=%b want 1 0 1 1",
                  ov1, s1, cy1, of1);
      end
      tick();
      n_tests++;
      if ({ov0, s0, cy0, of0} !== {1'b1, 8'd15, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL sub_pos got v=%b s=%0d c=%b o=%b want 1 15 0 0",
                  ov0, s0, cy0, of0);
      end
      n_tests++;
      if ({ov1, s1, cy1} !== {1'b1, 8'd15, 1'b0}) begin
         n_fail++;
         $display("FAIL sub_pos_sat got v=%b s=%0d c=%b want 1 15 0",
                  ov1, s1, cy1);
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_q [3];
      exp_q[0] = 8'd25;
      exp_q[1] = 8'd55;
      exp_q[2] = 8'd2;
      drive(1'b1, 8'd15, 8'd10, 1'b0);
      tick();
      drive(1'b1, 8'd25, 8'd30, 1'b0);
      tick();
      drive(1'b1, 8'd1, 8'd1, 1'b0);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++;
         if ({rdy0, ov0, s0} !== {1'b0, 1'b1, 8'd25}) begin
            n_fail++;
            $display("FAIL stall_%0d got rdy=%b v=%b s=%0d want 0 1 25",
                     i, rdy0, ov0, s0);
         end
         tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++;
         if ({ov0, s0} !== {1'b1, exp_q[i]}) begin
            n_fail++;
            $display("FAIL drain_%0d got v=%b s=%0d want 1 %0d",
                     i, ov0, s0, exp_q[i]);
         end
         tick();
         drive(1'b0, 8'd0, 8'd0, 1'b0);
      end
      n_tests++;
      if (ov0 !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_end got valid=%b want 0", ov0);
      end
   endtask

   task automatic test_mid_reset();
      drive(1'b1, 8'd50, 8'd60, 1'b0);
      tick();
      drive(1'b1, 8'd70, 8'd80, 1'b0);
      tick();
      drive(1'b0, 8'd0, 8'd0, 1'b0);
      #2;
      rstn = 1'b0;
      #1;
      n_tests++;
      if ({ov0, s0, cy0, of0, rdy0} !== 12'h001) begin
         n_fail++;
         $display("FAIL mid_rst got %h want 001",
                  {ov0, s0, cy0, of0, rdy0});
      end
      #1;
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (ov0 !== 1'b0 || ov1 !== 1'b0) begin
            n_fail++;
            $display("FAIL ghost_%0d got valid=%b/%b want 0/0",
                     i, ov0, ov1);
         end
      end
      drive(1'b1, 8'd3, 8'd4, 1'b0);
      tick();
      drive(1'b0, 8'd0, 8'd0, 1'b0);
      tick();
      n_tests++;
      if ({ov0, s0, cy0} !== {1'b1, 8'd7, 1'b0}) begin
         n_fail++;
         $display("FAIL post_rst got v=%b s=%0d c=%b want 1 7 0",
                  ov0, s0, cy0);
      end
   endtask

   task automatic test_first_edge();
      rstn = 1'b0;
      #3;
      drive(1'b1, 8'd100, 8'd28, 1'b0);
      rstn = 1'b1;
      tick();
      drive(1'b0, 8'd0, 8'd0, 1'b0);
      tick();
      n_tests++;
      if ({ov0, s0, cy0} !== {1'b1, 8'd128, 1'b0}) begin
         n_fail++;
         $display("FAIL first_edge got v=%b s=%0d c=%b want 1 128 0",
                  ov0, s0, cy0);
      end
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_overflow();
      test_borrow();
      test_backpressure();
      test_mid_reset();
      test_first_edge();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits (legal range 1..64).
REQ-002 Parameter STAGES, default 2, sets the number of pipeline register stages (legal range 1..4).
REQ-003 Parameter SAT, default 0: 0 = wrap-around result; 1 = unsigned saturating result.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rstn, input, 1 bit: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1 bit: an operand beat is presented.
REQ-007 Port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-008 Port a, input, WIDTH bits: unsigned operand A.
REQ-009 Port b, input, WIDTH bits: unsigned operand B.
REQ-010 Port sub, input, 1 bit: 0 = a+b; 1 = a-b.
REQ-011 Port out_valid, output, 1 bit: the result beat is valid.
REQ-012 Port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-013 Port sum, output, WIDTH bits: the result.
REQ-014 Port carry, output, 1 bit: raw carry-out (add) or borrow (sub).
REQ-015 Port ovf, output, 1 bit: the unsaturated result was out of range.

Function
REQ-016 A beat SHALL be accepted when in_valid && in_ready are high at a rising edge of clk.
REQ-017 The in_ready output SHALL be combinational: out_ready || !out_valid.
REQ-018 The pipeline SHALL advance as a whole when in_ready=1 and hold every stage (valid and data) when in_ready=0.
REQ-019 Each stage SHALL carry a valid bit. An empty slot (no beat accepted) SHALL propagate as a bubble with valid=0.
REQ-020 With out_ready held at 1, a beat accepted at edge N SHALL appear on out_valid/sum/carry/ovf after edge N+STAGES-1, so it is visible during cycle N+STAGES.
REQ-021 Add: the raw result SHALL be the (WIDTH+1)-bit a+b. Bit WIDTH is carry; bits WIDTH-1:0 are the wrapped sum.
REQ-022 Sub: the raw result SHALL be a-b modulo 2^WIDTH. Borrow is reported on carry when a<b.
REQ-023 ovf SHALL equal carry for both operations.
REQ-024 With SAT=0, sum SHALL be the wrapped result.
REQ-025 With SAT=1, sum SHALL be all-ones on add overflow and zero on sub borrow; otherwise it is the wrapped result.
REQ-026 The arithmetic SHALL be computed before the first register stage. Later stages SHALL only delay the beat.
REQ-027 While out_valid=1 and out_ready=0, sum, carry and ovf SHALL be held stable.
REQ-028 Beats SHALL emerge in acceptance order with none lost or duplicated.
REQ-029 Simultaneous output consume and input accept in the same cycle SHALL sustain a throughput of 1 beat per cycle.
REQ-030 a, b and sub SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-031 While rstn=0, all stage valid bits SHALL be cleared asynchronously, with out_valid=0, sum=0, carry=0 and ovf=0.
REQ-032 With out_valid=0 during reset, in_ready SHALL read 1.
REQ-033 Assertion of rstn mid-operation SHALL discard every in-flight beat; none SHALL appear after release.
REQ-034 The first beat SHALL be accepted at the first rising edge of clk after rstn deasserts.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-035 Reset: hold rstn=0 -> out_valid=0, sum=0, carry=0, ovf=0, in_ready=1.
REQ-036 Basic add: accept a=15, b=10, sub=0 at edge N with out_ready=1 -> sum=25, carry=0, ovf=0, out_valid=1 in cycle N+2 only.
REQ-037 Overflow: a=200, b=100 add -> with SAT=0, sum=44, carry=1, ovf=1; with SAT=1, sum=255, carry=1, ovf=1.
REQ-038 Borrow: a=10, b=25 sub -> with SAT=0, sum=241, carry=1; with SAT=1, sum=0, ovf=1. Also a=25, b=10 sub -> sum=15, carry=0.
REQ-039 Backpressure: stream (15+10), (25+30), (1+1) back-to-back, then drop out_ready for 3 cycles once out_valid=1 -> in_ready=0 during the stall, sum held at 25, then 25, 55, 2 delivered in order with no loss.
REQ-040 Mid-operation reset: with 2 beats in flight, pulse rstn=0 between clock edges -> out_valid drops immediately and no result appears after release. Then accepting 3+4 -> sum=7 after 2 cycles.
